// File: rtl/sum_pulse_counter.sv
// Per-pixel summed-hit counter with shutter-gated counting, saturation,
// sticky overflow and a parallel-load shift register that forms one link
// of the column readout daisy-chain.
module sum_pulse_counter #(
  parameter int CNT_W       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sumPulse,
  input  logic             shutter,
  input  logic             loadShift,
  input  logic             shiftEn,
  input  logic             serialIn,
  output logic             serialOut,
  output logic [CNT_W-1:0] count,
  output logic             countOverflow,
  output logic             counting
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   prev_q;
  logic                   event_q;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       sr_q, sr_d;
  logic                   counting_q;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Resynchronise the asynchronous hit pulse into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sumPulse};
    end
  end

  // Rising-edge detect on the synchronised pulse; the event is registered,
  // so a held level yields a single one-cycle event whatever the FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      event_q <= 1'b0;
    end else begin
      prev_q  <= sync_s;
      event_q <= sync_s & ~prev_q;
    end
  end

  // Next-state, counter and readout logic; entering COUNT clears the count
  // and overflow, and that clear takes precedence over a coincident event.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sr_d    = sr_q;
    case (state_q)
      IDLE: begin
        if (shutter) begin
          state_d = COUNT;
          cnt_d   = CNT_ZERO;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      COUNT: begin
        if (event_q) begin
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
        if (!shutter) begin
          state_d = HOLD;
        end else begin
          state_d = COUNT;
        end
      end
      HOLD: begin
        if (shutter) begin
          state_d = COUNT;
          cnt_d   = CNT_ZERO;
          ovf_d   = 1'b0;
        end else begin
          state_d = HOLD;
        end
        if (loadShift) begin
          sr_d = cnt_q;
        end else if (shiftEn) begin
          sr_d = {sr_q[CNT_W-2:0], serialIn};
        end else begin
          sr_d = sr_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, overflow and shift register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_ZERO;
      ovf_q      <= 1'b0;
      sr_q       <= CNT_ZERO;
      counting_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      sr_q       <= sr_d;
      counting_q <= (state_d == COUNT);
    end
  end

  assign serialOut     = sr_q[CNT_W-1];
  assign count         = cnt_q;
  assign countOverflow = ovf_q;
  assign counting      = counting_q;

endmodule

// File: tb/tb_sum_pulse_counter.sv
// Bench for sum_pulse_counter: two instances (12-bit/2-stage sync and
// 4-bit/3-stage sync) share stimulus and are compared every cycle against
// a sample-history reference model, plus hand-computed literal checks.
module tb_sum_pulse_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sumPulse = 1'b0;
  logic        shutter = 1'b0;
  logic        loadShift = 1'b0;
  logic        shiftEn = 1'b0;
  logic        serialIn = 1'b0;
  logic        serialOut0, serialOut1;
  logic [11:0] count0;
  logic [3:0]  count1;
  logic        ovf0, ovf1, counting0, counting1;

  int total = 0;
  int bad = 0;

  // Reference model state (0 idle, 1 counting, 2 holding)
  int   W_ARR[2] = '{12, 4};
  int   S_ARR[2] = '{2, 3};
  int   m_st[2];
  int   m_cnt[2];
  int   m_sr[2];
  bit   m_ovf[2];
  logic [7:0] hist;   // hist[k] = sumPulse sampled k+1 edges ago

  always #5 clk = ~clk;

  sum_pulse_counter #(.CNT_W(12), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sumPulse(sumPulse), .shutter(shutter),
    .loadShift(loadShift), .shiftEn(shiftEn), .serialIn(serialIn),
    .serialOut(serialOut0), .count(count0), .countOverflow(ovf0),
    .counting(counting0)
  );

  sum_pulse_counter #(.CNT_W(4), .SYNC_STAGES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sumPulse(sumPulse), .shutter(shutter),
    .loadShift(loadShift), .shiftEn(shiftEn), .serialIn(serialIn),
    .serialOut(serialOut1), .count(count1), .countOverflow(ovf1),
    .counting(counting1)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mask_of(input int i);
    return (1 << W_ARR[i]) - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_cnt[i] = 0; m_sr[i] = 0; m_ovf[i] = 1'b0;
    end
    hist = 8'd0;
  endtask

  // One clock edge of the reference model, using inputs sampled at the edge.
  // A counted event needs a 0->1 transition in the sampled input that is
  // SYNC_STAGES+1 edges old (the first high sample lands SYNC_STAGES+1 later).
  task automatic model_step();
    bit ev;
    int old_st, old_cnt;
    for (int i = 0; i < 2; i++) begin
      ev      = hist[S_ARR[i]] & ~hist[S_ARR[i] + 1];
      old_st  = m_st[i];
      old_cnt = m_cnt[i];
      if (old_st == 2) begin
        if (loadShift) m_sr[i] = old_cnt;
        else if (shiftEn) m_sr[i] = ((m_sr[i] << 1) | int'(serialIn)) & mask_of(i);
      end
      if (old_st == 1) begin
        if (ev) begin
          if (old_cnt == mask_of(i)) m_ovf[i] = 1'b1;
          else m_cnt[i] = old_cnt + 1;
        end
        if (!shutter) m_st[i] = 2;
      end else if (shutter) begin
        m_st[i] = 1; m_cnt[i] = 0; m_ovf[i] = 1'b0;
      end
    end
    hist = {hist[6:0], sumPulse};
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #2;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      sumPulse = 1'b1; ticks(hi);
      sumPulse = 1'b0; ticks(lo);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("count0", int'(count0), m_cnt[0]);
    chk("ovf0", int'(ovf0), int'(m_ovf[0]));
    chk("counting0", int'(counting0), int'(m_st[0] == 1));
    chk("serialOut0", int'(serialOut0), (m_sr[0] >> (W_ARR[0] - 1)) & 1);
    chk("count1", int'(count1), m_cnt[1]);
    chk("ovf1", int'(ovf1), int'(m_ovf[1]));
    chk("counting1", int'(counting1), int'(m_st[1] == 1));
    chk("serialOut1", int'(serialOut1), (m_sr[1] >> (W_ARR[1] - 1)) & 1);
  end

  initial begin
    logic [11:0] pat;
    int run_left;
    model_reset();
    // Reset and idle gating
    ticks(3);
    rst_n = 1'b1;
    chk("lit_reset_count", int'(count0), 0);
    chk("lit_reset_counting", int'(counting0), 0);
    pulses(2, 3, 3);
    chk("lit_idle_gate", int'(count0), 0);
    ticks(4);

    // Basic count with latency check
    shutter = 1'b1;
    tick();
    chk("lit_counting_rise", int'(counting0), 1);
    sumPulse = 1'b1;
    ticks(3);
    chk("lit_latency0_early", int'(count0), 0);
    tick();
    chk("lit_latency0", int'(count0), 1);
    chk("lit_latency1_early", int'(count1), 0);
    tick();
    chk("lit_latency1", int'(count1), 1);
    sumPulse = 1'b0;
    ticks(3);
    pulses(4, 3, 3);
    ticks(6);
    shutter = 1'b0;
    chk("lit_counting_hold", int'(counting0), 1);
    tick();
    chk("lit_counting_fall", int'(counting0), 0);
    chk("lit_basic_count", int'(count0), 5);
    chk("lit_basic_ovf", int'(ovf0), 0);

    // Gating in HOLD, then a level spanning shutter open
    pulses(3, 3, 3);
    ticks(6);
    chk("lit_hold_gate", int'(count0), 5);
    sumPulse = 1'b1;
    ticks(6);
    shutter = 1'b1;
    ticks(8);
    chk("lit_level_span", int'(count0), 0);
    sumPulse = 1'b0;
    ticks(3);

    // Saturation of the 4-bit instance, then reopen
    pulses(17, 2, 2);
    ticks(6);
    chk("lit_sat_count", int'(count1), 15);
    chk("lit_sat_ovf", int'(ovf1), 1);
    chk("lit_nosat_count", int'(count0), 17);
    shutter = 1'b0;
    tick();
    shutter = 1'b1;
    tick();
    chk("lit_reopen_count", int'(count1), 0);
    chk("lit_reopen_ovf", int'(ovf1), 0);

    // Readout of 0xA5C with serialIn = 1
    pulses(2652, 2, 2);
    ticks(6);
    shutter = 1'b0;
    ticks(2);
    loadShift = 1'b1;
    tick();
    loadShift = 1'b0;
    pat = 12'hA5C;
    chk("lit_load_bit11", int'(serialOut0), int'(pat[11]));
    shiftEn = 1'b1; serialIn = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("lit_shift_bit", int'(serialOut0), (k < 12) ? int'(pat[11 - k]) : 1);
    end
    chk("lit_count_kept", int'(count0), 2652);

    // Load wins over shift
    serialIn = 1'b0;
    ticks(12);
    chk("lit_sr_zero", int'(serialOut0), 0);
    loadShift = 1'b1;
    tick();
    chk("lit_load_priority", int'(serialOut0), 1);
    loadShift = 1'b0; shiftEn = 1'b0;

    // Readout requests ignored while counting
    shutter = 1'b1;
    tick();
    loadShift = 1'b1; shiftEn = 1'b1; serialIn = 1'b0;
    ticks(3);
    chk("lit_ignore_count", int'(serialOut0), 1);
    loadShift = 1'b0; shiftEn = 1'b0;

    // Reset mid-count
    pulses(7, 3, 3);
    ticks(6);
    chk("lit_pre_reset", int'(count0), 7);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("lit_rst_count0", int'(count0), 0);
    chk("lit_rst_counting0", int'(counting0), 0);
    chk("lit_rst_count1", int'(count1), 0);
    chk("lit_rst_counting1", int'(counting1), 0);
    ticks(2);
    rst_n = 1'b1;
    shutter = 1'b0;
    pulses(3, 3, 3);
    ticks(6);
    chk("lit_post_reset", int'(count0), 0);
    chk("lit_post_reset_counting", int'(counting0), 0);

    // Reset mid-shift
    shutter = 1'b1;
    tick();
    pulses(3, 2, 2);
    ticks(6);
    shutter = 1'b0;
    tick();
    loadShift = 1'b1;
    tick();
    loadShift = 1'b0; shiftEn = 1'b1; serialIn = 1'b1;
    ticks(13);
    chk("lit_pre_rst_shift", int'(serialOut0), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("lit_rst_serial", int'(serialOut0), 0);
    shiftEn = 1'b0; serialIn = 1'b0;
    ticks(2);
    rst_n = 1'b1;

    // Randomised phase
    run_left = 3;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 24) == 0) shutter = ~shutter;
      loadShift = ($urandom_range(0, 7) == 0);
      shiftEn   = $urandom_range(0, 1) == 1;
      serialIn  = $urandom_range(0, 1) == 1;
      run_left--;
      if (run_left == 0) begin
        sumPulse = ~sumPulse;
        run_left = $urandom_range(2, 5);
      end
      tick();
    end
    ticks(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
